// File: rtl/vga_sync_receiver_if.sv
// VGA receive-side bundle: sync/RGB samples in, recovered pixel stream out.
interface vga_sync_receiver_if;
    logic       hsync;
    logic       vsync;
    logic [2:0] red_in;
    logic [2:0] green_in;
    logic [1:0] blue_in;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] pixel_rgb;
    logic       pixel_valid;
    logic       frame_start;
    logic       locked;
    logic       timing_err;

    // Transmitter / capture side
    modport master (
        output hsync, vsync, red_in, green_in, blue_in,
        input  pixel_x, pixel_y, pixel_rgb, pixel_valid, frame_start, locked, timing_err
    );

    // Receiver side
    modport slave (
        input  hsync, vsync, red_in, green_in, blue_in,
        output pixel_x, pixel_y, pixel_rgb, pixel_valid, frame_start, locked, timing_err
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers raster position from hsync/vsync, checks
// line/frame timing, tracks lock and emits active-video pixels two edges
// after capture.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 521,
    parameter int H_PULSE     = 96,
    parameter int V_PULSE     = 2,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_sync_receiver_if.slave vid
);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_PW   = 10'(H_PULSE);
    localparam logic [9:0] V_PW   = 10'(V_PULSE);
    localparam logic [9:0] H_BEG  = 10'(HBP);
    localparam logic [9:0] H_END  = 10'(HFP);
    localparam logic [9:0] V_BEG  = 10'(VBP);
    localparam logic [9:0] V_END  = 10'(VFP);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [9:0] SAT    = 10'h3FF;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [3:0] good_q, good_d;
    logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [7:0] rgb_q;
    logic [9:0] h_pos_q, v_pos_q, hw_q, vw_q;
    logic [9:0] h_pos, v_pos;
    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic       line_err, tmo_err, frm_err, viol, valid;
    logic [9:0] px_q, py_q;
    logic [7:0] prgb_q;
    logic       pvalid_q, fstart_q, terr_q;

    assign hs_fall = hs_prev_q & ~hs_q;
    assign hs_rise = ~hs_prev_q & hs_q;
    assign vs_fall = vs_prev_q & ~vs_q;
    assign vs_rise = ~vs_prev_q & vs_q;

    // Stage 1: capture sync/RGB and keep the previous sync levels for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            rgb_q     <= '0;
        end else begin
            hs_q      <= vid.hsync;
            vs_q      <= vid.vsync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            rgb_q     <= {vid.red_in, vid.green_in, vid.blue_in};
        end
    end

    // Raster position of the stage-1 sample; both counters saturate so a dead link cannot wrap
    always_comb begin
        h_pos = (h_pos_q == SAT) ? h_pos_q : h_pos_q + 10'd1;
        if (hs_fall) h_pos = '0;
        v_pos = v_pos_q;
        if (hs_fall) v_pos = vs_fall ? '0 : ((v_pos_q == SAT) ? v_pos_q : v_pos_q + 10'd1);
    end

    // Line/frame checks use the previous line's length and the pulse widths latched at the rising edges
    always_comb begin
        line_err = hs_fall && (h_pos_q != H_LAST || hw_q != H_PW);
        tmo_err  = !hs_fall && (h_pos == H_TOT);
        frm_err  = vs_fall && (!hs_fall || v_pos_q != V_LAST || vw_q != V_PW);
        viol     = line_err || tmo_err || frm_err;
    end

    // Position counters and sync-pulse width capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_pos_q <= '0;
            v_pos_q <= '0;
            hw_q    <= '0;
            vw_q    <= '0;
        end else begin
            h_pos_q <= h_pos;
            v_pos_q <= v_pos;
            if (hs_rise) hw_q <= h_pos;
            if (vs_rise) vw_q <= v_pos;
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Lock FSM next state: a violation always beats a lock completion in the same cycle
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (viol) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    good_d = good_q + 4'd1;
                    if (good_d == LOCK_N) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (viol) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    assign valid = (state_q == LOCKED) && (h_pos >= H_BEG) && (h_pos < H_END)
                   && (v_pos >= V_BEG) && (v_pos < V_END);

    // Stage 2: registered pixel stream; fields are zeroed outside active video
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pvalid_q <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            prgb_q   <= '0;
            fstart_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            pvalid_q <= valid;
            px_q     <= valid ? h_pos - H_BEG : '0;
            py_q     <= valid ? v_pos - V_BEG : '0;
            prgb_q   <= valid ? rgb_q : '0;
            fstart_q <= valid && (h_pos == H_BEG) && (v_pos == V_BEG);
            terr_q   <= viol && (state_q != SEARCH);
        end
    end

    assign vid.pixel_valid = pvalid_q;
    assign vid.pixel_x     = px_q;
    assign vid.pixel_y     = py_q;
    assign vid.pixel_rgb   = prgb_q;
    assign vid.frame_start = fstart_q;
    assign vid.locked      = (state_q == LOCKED);
    assign vid.timing_err  = terr_q;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized bench for vga_sync_receiver. Raster is scaled down (40x20) so
// many frames fit in a short run; the reference model tracks sync edges by
// sample timestamps and line counts and predicts every output sample.
module tb_vga_sync_receiver;
  localparam int HT = 40, HPW = 6, HB = 10, HF = 34;
  localparam int VT = 20, VPW = 2, VB = 4, VF = 18, LF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_sync_receiver_if vid();

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_PULSE(HPW), .V_PULSE(VPW),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vid(vid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int locks_seen = 0, errs_seen = 0;

  // model state: sample index, index of last hsync fall, latched widths, line count, lock state
  int m_t, m_thf, m_hw, m_vw, m_v, m_good, m_st;
  bit m_phs, m_pvs;
  logic [31:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {vid.pixel_valid, vid.pixel_x, vid.pixel_y, vid.pixel_rgb,
            vid.frame_start, vid.locked, vid.timing_err};
  endfunction

  function automatic int sat(input int a);
    return (a > 1023) ? 1023 : a;
  endfunction

  task automatic model_reset();
    m_t = 0; m_thf = -1; m_hw = 0; m_vw = 0; m_v = 0; m_good = 0; m_st = 0;
    m_phs = 1'b1; m_pvs = 1'b1;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [7:0] rgb,
                            output logic [31:0] e);
    bit hf, hr, vf, vr, viol, val;
    int h, hp, vp, old;
    hf = m_phs && !hs;  hr = !m_phs && hs;
    vf = m_pvs && !vs;  vr = !m_pvs && vs;
    hp = sat(m_t - 1 - m_thf);
    h  = hf ? 0 : sat(m_t - m_thf);
    vp = m_v;
    if (hf) m_v = vf ? 0 : sat(m_v + 1);
    viol = (hf && (hp + 1 != HT || m_hw != HPW)) || (!hf && h == HT)
           || (vf && (!hf || vp + 1 != VT || m_vw != VPW));
    if (hr) m_hw = h;
    if (vr) m_vw = m_v;
    if (hf) m_thf = m_t;
    old = m_st;
    case (m_st)
      0: if (vf) begin m_st = 1; m_good = 0; end
      1: if (viol) m_st = 0;
         else if (vf) begin m_good++; if (m_good == LF) m_st = 2; end
      default: if (viol) m_st = 0;
    endcase
    val = (old == 2) && h >= HB && h < HF && m_v >= VB && m_v < VF;
    e = {val, val ? 10'(h - HB) : 10'd0, val ? 10'(m_v - VB) : 10'd0,
         val ? rgb : 8'd0, val && h == HB && m_v == VB, m_st == 2, viol && old != 0};
    m_phs = hs; m_pvs = vs; m_t++;
  endtask

  // One pixel clock: check the output due for the sample driven two edges ago, then drive
  task automatic tick(input bit hs, input bit vs);
    logic [31:0] e;
    logic [7:0]  rgb;
    @(negedge clk);
    if (expq.size() == 2) chk("pix", obs(), expq.pop_front());
    if (vid.locked) locks_seen++;
    if (vid.timing_err) errs_seen++;
    rgb = 8'($urandom);
    vid.hsync = hs; vid.vsync = vs;
    {vid.red_in, vid.green_in, vid.blue_in} = rgb;
    model_step(hs, vs, rgb, e);
    expq.push_back(e);
  endtask

  task automatic do_reset();
    logic [31:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    vid.hsync = 1'b1; vid.vsync = 1'b1;
    {vid.red_in, vid.green_in, vid.blue_in} = 8'h00;
    @(negedge clk);
    chk("rst", obs(), 32'h0);
    rst_n = 1'b1;
    expq.delete();
    model_reset();
    model_step(1'b1, 1'b1, 8'h00, e);
    expq.push_back(e);
  endtask

  task automatic drive_line(input int len, input int hpw, input bit vsa, input bit vsb,
                            input int split);
    for (int hc = 0; hc < len; hc++) tick(hc >= hpw, (hc < split) ? vsa : vsb);
  endtask

  // bad_ln gets length bad_len / pulse bad_hpw; orph_ln drops vsync mid-line; stop truncates
  task automatic drive_frame(input int nl, input int vpw, input int bad_ln, input int bad_len,
                             input int bad_hpw, input int orph_ln, input int stop);
    for (int ln = 0; ln < nl && ln < stop; ln++) begin
      int len, hpw;
      bit vsl;
      len = (ln == bad_ln) ? bad_len : HT;
      hpw = (ln == bad_ln) ? bad_hpw : HPW;
      vsl = (ln >= vpw);
      if (ln == orph_ln) drive_line(len, hpw, 1'b1, 1'b0, len / 2);
      else               drive_line(len, hpw, vsl, vsl, len);
    end
  endtask

  task automatic clean_frame();
    drive_frame(VT, VPW, -1, 0, 0, -1, VT);
  endtask

  initial begin
    int k;
    vid.hsync = 1'b1; vid.vsync = 1'b1;
    {vid.red_in, vid.green_in, vid.blue_in} = 8'h00;
    do_reset();

    // nominal timing from reset: acquisition starts at the first vsync edge
    repeat (5) clean_frame();
    chk("lock_nominal", {31'd0, vid.locked}, 32'd1);

    for (int f = 0; f < 30; f++) begin
      k = $urandom_range(0, 11);
      if (k <= 5) clean_frame();
      else if (k == 6)
        drive_frame(VT, VPW, $urandom_range(0, VT - 1), ($urandom_range(0, 1) != 0) ? HT - 1 : HT + 1,
                    HPW, -1, VT);
      else if (k == 7)
        drive_frame(VT, VPW, $urandom_range(0, VT - 1), HT,
                    ($urandom_range(0, 1) != 0) ? HPW - 1 : HPW + 1, -1, VT);
      else if (k == 8)
        drive_frame(($urandom_range(0, 1) != 0) ? VT - 1 : VT + 1, VPW, -1, 0, 0, -1, VT + 1);
      else if (k == 9)
        drive_frame(VT, ($urandom_range(0, 1) != 0) ? VPW - 1 : VPW + 1, -1, 0, 0, -1, VT);
      else if (k == 10) begin
        // stuck-high hsync, long enough at times to reach the position saturation
        repeat ($urandom_range(HT, 1100)) tick(1'b1, 1'b1);
        clean_frame();
      end else if ($urandom_range(0, 1) != 0)
        drive_frame(VT, VPW, -1, 0, 0, $urandom_range(4, VT - 3), VT);
      else begin
        drive_frame(VT, VPW, -1, 0, 0, -1, $urandom_range(3, VT - 2));
        do_reset();
      end
    end

    // recovery after the disturbances
    repeat (4) clean_frame();
    chk("lock_final", {31'd0, vid.locked}, 32'd1);
    chk("lock_seen", {31'd0, locks_seen > 0}, 32'd1);
    chk("err_seen", {31'd0, errs_seen > 0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
